sine_voice_scheduler: RTL and testbench

//  Time-multiplexes one single-port quarter-sine block ROM (1-cycle read latency) between NUM_VOICES tone voices.
//  Per voice: phase accumulator, quadrant folding, offset-binary sample reconstruction.

---
 rtl/sine_voice_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_sine_voice_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one quarter-sine ROM across NUM_VOICES phase-accumulator voices and mixes them.
// Optional per-voice attenuation input is enabled with `define VOICE_ATTEN_EN.
module sine_voice_scheduler #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 11,
  parameter int unsigned PHASE_W    = 24
) (
  input  logic                           CLK100MHZ,
  input  logic                           rst,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [NUM_VOICES*PHASE_W-1:0]  phase_inc,
`ifdef VOICE_ATTEN_EN
  input  logic [2*NUM_VOICES-1:0]        voice_atten,
`endif
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [DATA_W-2:0]              rom_data,
  output logic [NUM_VOICES*DATA_W-1:0]   voice_sample,
  output logic [DATA_W-1:0]              mix_out,
  output logic                           mix_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int unsigned VOICE_W = $clog2(NUM_VOICES);
  localparam int unsigned SUM_W   = DATA_W + VOICE_W;
  localparam int unsigned CNT_W   = $clog2(NUM_VOICES + 3);
  localparam int unsigned MID     = 1 << (DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, MIX} state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cyc;
  logic [NUM_VOICES-1:0]          en_lat;
  logic [NUM_VOICES*PHASE_W-1:0]  inc_lat;
  logic [NUM_VOICES-1:0]          neg;
  logic [PHASE_W-1:0]             phase  [NUM_VOICES];
  logic signed [DATA_W-1:0]       shadow [NUM_VOICES];
`ifdef VOICE_ATTEN_EN
  logic [2*NUM_VOICES-1:0]        atten_lat;
`endif

  logic                           accept_c;
  logic                           issue_go_c;
  logic [VOICE_W-1:0]             issue_v_c;
  logic                           issue_en_c;
  logic [PHASE_W-1:0]             issue_inc_c;
  logic                           capture_go_c;
  logic [VOICE_W-1:0]             cap_v_c;
  logic                           load_c;
  logic signed [DATA_W-1:0]       off_raw_c;
  logic signed [DATA_W-1:0]       off_c;
  logic signed [SUM_W-1:0]        sum_c;
  logic [DATA_W-1:0]              mix_c;

  function automatic logic [ADDR_W-1:0] fold_addr(input logic [PHASE_W-1:0] p);
    logic [ADDR_W-1:0] idx;
    idx = p[PHASE_W-3 -: ADDR_W];
    return p[PHASE_W-2] ? ~idx : idx;
  endfunction

  always_ff @(posedge CLK100MHZ) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Sequencing: voice i issues at edge i, its ROM data is captured at edge i+2, MIX follows the last capture.
  always_comb begin
    state_nxt    = state;
    accept_c     = 1'b0;
    issue_go_c   = 1'b0;
    issue_v_c    = '0;
    issue_en_c   = 1'b0;
    issue_inc_c  = '0;
    capture_go_c = 1'b0;
    cap_v_c      = '0;
    load_c       = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          state_nxt   = SWEEP;
          accept_c    = 1'b1;
          issue_go_c  = 1'b1;
          issue_en_c  = voice_en[0];
          issue_inc_c = phase_inc[PHASE_W-1:0];
        end
      end
      SWEEP: begin
        issue_go_c  = 1'b1;
        issue_v_c   = VOICE_W'(cyc);
        issue_en_c  = en_lat[issue_v_c];
        issue_inc_c = inc_lat[issue_v_c*PHASE_W +: PHASE_W];
        if (cyc == CNT_W'(NUM_VOICES - 1)) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (cyc == CNT_W'(NUM_VOICES + 1)) state_nxt = MIX;
      end
      MIX: begin
        load_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if ((state == SWEEP || state == FLUSH) && cyc >= CNT_W'(2)) begin
      capture_go_c = 1'b1;
      cap_v_c      = VOICE_W'(cyc - CNT_W'(2));
    end
  end

  // Signed offset of the captured magnitude, optionally attenuated.
  always_comb begin
    off_raw_c = neg[cap_v_c] ? -$signed({1'b0, rom_data}) : $signed({1'b0, rom_data});
`ifdef VOICE_ATTEN_EN
    off_c = off_raw_c >>> atten_lat[2*cap_v_c +: 2];
`else
    off_c = off_raw_c;
`endif
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) sum_c = sum_c + SUM_W'(shadow[i]);
    mix_c = DATA_W'(MID) + DATA_W'($unsigned(sum_c >>> VOICE_W));
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      rom_addr  <= '0;
      mix_out   <= DATA_W'(MID);
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      cyc       <= '0;
      en_lat    <= '0;
      inc_lat   <= '0;
      neg       <= '0;
`ifdef VOICE_ATTEN_EN
      atten_lat <= '0;
`endif
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
        phase[i]                         <= '0;
        shadow[i]                        <= '0;
        voice_sample[i*DATA_W +: DATA_W] <= DATA_W'(MID);
      end
    end else begin
      mix_valid <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;

      if (accept_c) begin
        en_lat  <= voice_en;
        inc_lat <= phase_inc;
`ifdef VOICE_ATTEN_EN
        atten_lat <= voice_atten;
`endif
        busy <= 1'b1;
        cyc  <= CNT_W'(1);
      end else if (state == MIX) begin
        cyc <= '0;
      end else if (state != IDLE) begin
        cyc <= cyc + CNT_W'(1);
      end

      // Address uses the pre-increment phase; disabled voices park at phase 0.
      if (issue_go_c) begin
        rom_addr           <= issue_en_c ? fold_addr(phase[issue_v_c]) : '0;
        phase[issue_v_c]   <= issue_en_c ? phase[issue_v_c] + issue_inc_c : '0;
        neg[issue_v_c]     <= phase[issue_v_c][PHASE_W-1];
      end

      if (capture_go_c) shadow[cap_v_c] <= en_lat[cap_v_c] ? off_c : '0;

      if (load_c) begin
        for (int i = 0; i < int'(NUM_VOICES); i++)
          voice_sample[i*DATA_W +: DATA_W] <= DATA_W'(MID) + $unsigned(shadow[i]);
        mix_out   <= mix_c;
        mix_valid <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Directed self-checking bench for sine_voice_scheduler with a 4*addr quarter-sine ROM model.
`timescale 1ns/1ps
module tb_sine_voice_scheduler;

  logic        clk;
  logic        rst;
  logic        sample_tick;
  logic [3:0]  voice_en;
  logic [95:0] phase_inc;
  logic [7:0]  rom_addr;
  logic [9:0]  rom_data;
  logic [43:0] voice_sample;
  logic [10:0] mix_out;
  logic        mix_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  sine_voice_scheduler dut (
    .CLK100MHZ    (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .voice_en     (voice_en),
    .phase_inc    (phase_inc),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .voice_sample (voice_sample),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= {rom_addr, 2'b00};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_tick = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic run_sweep(output logic [7:0] a0);
    logic seen;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    a0 = rom_addr;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (mix_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL sweep_timeout got=%0b want=1", seen);
    end
  endtask

  task automatic test_reset();
    voice_en = 4'b0000;
    phase_inc = '0;
    do_reset();
    checks++;
    if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr got=%0d want=0", rom_addr); end
    checks++;
    if (mix_out !== 11'd1024) begin errors++; $display("FAIL reset_mix_out got=%0d want=1024", mix_out); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (voice_sample[i*11 +: 11] !== 11'd1024) begin
        errors++;
        $display("FAIL reset_voice_sample%0d got=%0d want=1024", i, voice_sample[i*11 +: 11]);
      end
    end
    checks++;
    if ({mix_valid, busy, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000", {mix_valid, busy, overrun});
    end
  endtask

  task automatic test_single_voice();
    logic [7:0]  a0;
    logic [7:0]  exp_addr [4];
    logic [10:0] exp_vs0  [4];
    logic [10:0] exp_mix  [4];
    exp_addr = '{8'd0, 8'd255, 8'd0, 8'd255};
    exp_vs0  = '{11'd1024, 11'd2044, 11'd1024, 11'd4};
    exp_mix  = '{11'd1024, 11'd1279, 11'd1024, 11'd769};
    do_reset();
    voice_en = 4'b0001;
    phase_inc = '0;
    phase_inc[23:0] = 24'h400000;
    for (int t = 0; t < 4; t++) begin
      run_sweep(a0);
      checks++;
      if (a0 !== exp_addr[t]) begin errors++; $display("FAIL single_addr t%0d got=%0d want=%0d", t, a0, exp_addr[t]); end
      checks++;
      if (voice_sample[10:0] !== exp_vs0[t]) begin
        errors++;
        $display("FAIL single_vs0 t%0d got=%0d want=%0d", t, voice_sample[10:0], exp_vs0[t]);
      end
      checks++;
      if (mix_out !== exp_mix[t]) begin errors++; $display("FAIL single_mix t%0d got=%0d want=%0d", t, mix_out, exp_mix[t]); end
    end
    checks++;
    if (voice_sample[43:11] !== {3{11'd1024}}) begin
      errors++;
      $display("FAIL single_disabled_voices got=%h want=%h", voice_sample[43:11], {3{11'd1024}});
    end
  endtask

  task automatic test_all_voices();
    logic [7:0] a0;
    do_reset();
    voice_en = 4'b1111;
    phase_inc = {4{24'h400000}};
    run_sweep(a0);
    checks++;
    if (mix_out !== 11'd1024) begin errors++; $display("FAIL all_mix_first got=%0d want=1024", mix_out); end
    run_sweep(a0);
    checks++;
    if (mix_out !== 11'd2044) begin errors++; $display("FAIL all_mix_second got=%0d want=2044", mix_out); end
    checks++;
    if (voice_sample !== {4{11'd2044}}) begin
      errors++;
      $display("FAIL all_voice_samples got=%h want=%h", voice_sample, {4{11'd2044}});
    end
  endtask

  task automatic test_timing();
    int mv_edge, mv_count, busy_count;
    do_reset();
    voice_en = 4'b1111;
    phase_inc = {4{24'h400000}};
    mv_edge = -1;
    mv_count = 0;
    busy_count = 0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    if (busy) busy_count++;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (busy) busy_count++;
      if (mix_valid) begin
        mv_count++;
        if (mv_edge < 0) mv_edge = e;
      end
    end
    checks++;
    if (mv_edge != 6) begin errors++; $display("FAIL timing_mix_valid_edge got=%0d want=6", mv_edge); end
    checks++;
    if (mv_count != 1) begin errors++; $display("FAIL timing_mix_valid_width got=%0d want=1", mv_count); end
    checks++;
    if (busy_count != 6) begin errors++; $display("FAIL timing_busy_cycles got=%0d want=6", busy_count); end
  endtask

  task automatic test_overrun();
    int mv_count;
    do_reset();
    voice_en = 4'b0001;
    phase_inc = '0;
    phase_inc[23:0] = 24'h400000;
    mv_count = 0;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%0b want=1", overrun); end
    for (int e = 4; e <= 6; e++) begin
      step();
      if (mix_valid) mv_count++;
    end
    checks++;
    if (mv_count != 1) begin errors++; $display("FAIL overrun_one_mix got=%0d want=1", mv_count); end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL overrun_edge7_accept got=%0b want=1", busy); end
    mv_count = 0;
    for (int e = 8; e <= 14; e++) begin
      step();
      if (mix_valid) mv_count++;
    end
    checks++;
    if (mv_count != 1 || mix_out !== 11'd1279) begin
      errors++;
      $display("FAIL overrun_second_sweep mix_valid=%0d mix_out=%0d want 1 and 1279", mv_count, mix_out);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%0b want=1", overrun); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a0;
    int mv_count;
    do_reset();
    voice_en = 4'b0001;
    phase_inc = '0;
    phase_inc[23:0] = 24'h400000;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, mix_valid, overrun} !== 3'b000 || rom_addr !== 8'd0 || mix_out !== 11'd1024) begin
      errors++;
      $display("FAIL midreset_state busy/mv/ovr=%b addr=%0d mix=%0d want 000 0 1024",
               {busy, mix_valid, overrun}, rom_addr, mix_out);
    end
    mv_count = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (mix_valid) mv_count++;
    end
    checks++;
    if (mv_count != 0) begin errors++; $display("FAIL midreset_no_mix got=%0d want=0", mv_count); end
    run_sweep(a0);
    checks++;
    if (a0 !== 8'd0 || voice_sample[10:0] !== 11'd1024) begin
      errors++;
      $display("FAIL midreset_first addr=%0d vs0=%0d want 0 1024", a0, voice_sample[10:0]);
    end
    run_sweep(a0);
    checks++;
    if (a0 !== 8'd255 || voice_sample[10:0] !== 11'd2044 || mix_out !== 11'd1279) begin
      errors++;
      $display("FAIL midreset_second addr=%0d vs0=%0d mix=%0d want 255 2044 1279", a0, voice_sample[10:0], mix_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    sample_tick = 1'b0;
    voice_en = '0;
    phase_inc = '0;
    test_reset();
    test_single_voice();
    test_all_voices();
    test_timing();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
